// File: rtl/cola_destinos_fifo.sv
// cola_destinos_fifo: circular FIFO of destination words between the request
// decoder and the dispatcher. It has a valid/ready handshake on both sides,
// an occupancy count, full/empty flags, a flush, and a sticky overflow flag.
// Optional build macro COLA_DEDUP_EN drops a push whose data already sits in
// the queue and pulses dup_hit for that push. Without it no comparators are
// built and dup_hit is tied low.
module cola_destinos_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  input  logic              pop_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              dup_hit
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              push_fire, pop_fire, store, dup;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign pop_data   = mem[rd_ptr];
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop_valid & pop_ready;
  assign store      = push_fire & ~dup;

`ifdef COLA_DEDUP_EN
  // Match the incoming word against every live entry. The head is skipped
  // when it is leaving this cycle, so re-pushing it is not treated as a duplicate.
  always_comb begin
    int offs;
    dup  = 1'b0;
    offs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = (i >= int'(rd_ptr)) ? i - int'(rd_ptr) : i + DEPTH - int'(rd_ptr);
      if (offs < int'(count) && !(pop_fire && offs == 0) && mem[i] == push_data)
        dup = 1'b1;
    end
  end

  // One-cycle pulse for a push that was dropped as a duplicate.
  always_ff @(posedge clk) begin
    if (rst || clear) dup_hit <= 1'b0;
    else              dup_hit <= push_fire & dup;
  end
`else
  assign dup     = 1'b0;
  assign dup_hit = 1'b0;
`endif

  // Storage is not reset. A flushed cycle writes nothing.
  always_ff @(posedge clk) begin
    if (!rst && !clear && store) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and sticky overflow. Reset and flush both return to empty.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (store)    wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop_fire) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (store && !pop_fire)      count <= count + 1'b1;
      else if (!store && pop_fire) count <= count - 1'b1;
      if (push_valid && full) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/cola_destinos_fifo.md
Name: cola_destinos_fifo

Overview:
- Parametrised successor to the fixed external-destination queue. Replaces the address-indexed lookup with a clocked circular FIFO of destination words.
- Has a push/pop valid-ready handshake, occupancy count, full/empty flags, a flush input and a sticky overflow flag.
- Sits between the destination-request source (button/request decoder) and the dispatcher that consumes destinations one at a time.

Parameters:
- DATA_W, 24, width of one destination word.
- DEPTH, 8, number of entries; any integer >= 2 (not restricted to powers of two).
- CNT_W, $clog2(DEPTH+1), width of the count output (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush; empties queue, clears overflow.
- push_valid  in  1  request to enqueue push_data.
- push_data  in  DATA_W  destination to enqueue.
- push_ready  out  1  queue can accept this cycle.
- pop_valid  out  1  head entry is valid.
- pop_data  out  DATA_W  head destination (mem[rd_ptr]).
- pop_ready  in  1  consumer takes head this cycle.
- count  out  CNT_W  current number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: a push was attempted while full.
- dup_hit  out  1  one-cycle pulse: push dropped as duplicate (optional feature only).

Behaviour:
- Reset: rst high at a rising edge -> wr_ptr=0, rd_ptr=0, count=0, overflow=0, dup_hit=0.
  - After reset: empty=1, full=0, push_ready=1, pop_valid=0.
  - Storage contents are not reset; pop_data is don't-care while empty.
  - rst has priority over clear, push and pop.
- push_fire = push_valid & push_ready. pop_fire = pop_valid & pop_ready.
- push_ready = !full. pop_valid = !empty. Both are combinational from count.
- pop_data = mem[rd_ptr], combinational (fall-through). It is valid in the same cycle pop_valid rises, i.e. one cycle after the push edge.
- On push_fire: mem[wr_ptr] <= push_data; wr_ptr advances, wrapping DEPTH-1 -> 0.
- On pop_fire: rd_ptr advances, wrapping DEPTH-1 -> 0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged (legal whenever 0 < count < DEPTH).
- Full: push_ready=0, so push_valid is ignored and the entry is not stored; overflow <= 1. A simultaneous pop still proceeds, and push_ready rises the next cycle. There is no same-cycle bypass.
- Empty: pop_ready is ignored. A simultaneous push is stored, and pop_valid=1 the next cycle.
- clear (rst low): pointers <= 0, count <= 0, overflow <= 0. Any push/pop in the same cycle is discarded.
- Reset or clear mid-operation: the queue is empty the next cycle; no partial state survives.
- Latency: push -> visible at head when the queue was empty = 1 cycle.
- Throughput: one push and one pop per cycle.

Optional Feature:
- Macro: COLA_DEDUP_EN.
- Defined: on push_fire, push_data is compared against every valid stored entry.
  - Match: the push is accepted (push_ready unchanged) but not stored; wr_ptr and count are unaffected by the push; dup_hit=1 for the cycle after the edge.
  - If pop_fire occurs in the same cycle, the head entry being popped is excluded from the comparison, so a matching push is stored.
  - Duplicate check does not affect overflow; full still blocks the push.
- Not defined: no comparators are built, dup_hit is tied to 0, and duplicates are stored normally.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> count=0, empty=1, full=0, push_ready=1, pop_valid=0, overflow=0.
- Ordered fill/drain, DEPTH=8: push 10,20,...,80 on consecutive cycles -> full=1, count=8; pop 8 times -> pop_data sequence 10..80, empty=1.
- Full/overflow, full queue: push_valid=1 data=99 -> not stored, overflow=1; same cycle pop -> next cycle count=7, push_ready=1, overflow remains 1 until clear.
- Wrap and simultaneous events: keep count at 3 while doing push+pop every cycle for 20 cycles -> count stays 3, FIFO order preserved across pointer wrap; clear asserted mid-stream -> count=0 and overflow=0 next cycle.
- Dedup, with COLA_DEDUP_EN defined:
  - Queue holds 5,7; push 7 -> dup_hit pulse, count stays 2.
  - Pop head 5 while pushing 5 -> 5 is stored, count=2.
  - With the macro not defined: the same pushes of 7 store it, count=3, dup_hit=0.
